// File: rtl/host_ft245_pkg.sv
`default_nettype none
// ============================================================================
// Module   : host_ft245_pkg
// Purpose  : Shared state encoding and default widths for the FT245 host-side
//            burst read model and its byte queue.
// Revision : 1.0 - initial release
// ============================================================================
package host_ft245_pkg;

  // Default widths used when the model is instantiated without overrides
  localparam int c_default_data_w = 8;
  localparam int c_default_len_w  = 8;

  // One-hot state bit positions
  localparam int c_st_count           = 6;
  localparam int c_st_idle_idx        = 0;
  localparam int c_st_assert_rxf_idx  = 1;
  localparam int c_st_wait_rd_low_idx = 2;
  localparam int c_st_wait_rd_hi_idx  = 3;
  localparam int c_st_rxf_gap_idx     = 4;
  localparam int c_st_complete_idx    = 5;

  localparam logic [c_st_count-1:0] c_st_one = 1;

  typedef enum logic [c_st_count-1:0] {
    ST_IDLE          = c_st_one << c_st_idle_idx,
    ST_ASSERT_RXF_N  = c_st_one << c_st_assert_rxf_idx,
    ST_WAIT_RD_LOW   = c_st_one << c_st_wait_rd_low_idx,
    ST_WAIT_RD_HIGH  = c_st_one << c_st_wait_rd_hi_idx,
    ST_RXF_GAP       = c_st_one << c_st_rxf_gap_idx,
    ST_READ_COMPLETE = c_st_one << c_st_complete_idx
  } state_t;

endpackage : host_ft245_pkg
`default_nettype wire

// File: rtl/host_ft245_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : host_ft245_byte_fifo
// Purpose  : Synchronous first-word-fall-through byte queue. Head entry is
//            always visible on head_data; push when full and pop when empty
//            are ignored. FIFO_DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module host_ft245_byte_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int c_addr_w = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_level;
  logic                w_do_push;
  logic                w_do_pop;

  assign full      = (r_level == (c_addr_w+1)'(FIFO_DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign head_data = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule : host_ft245_byte_fifo
`default_nettype wire

// File: rtl/host_ft245_burst_read_model.sv
`default_nettype none
// ============================================================================
// Module   : host_ft245_burst_read_model
// Purpose  : Host-side FT245 read-channel model. Queues bench bytes and hands
//            them to the DUT read engine in bursts, one byte per RXF_N low /
//            RD_N strobe handshake, with an RXF_N inactive gap between bytes.
// Options  : FT245_PROTOCOL_CHECK_EN - enables the sticky PROTOCOL_ERR flag
//            and the WAIT_RD_LOW timeout (RXF_N released, burst completed).
// Revision : 1.0 - initial release
// ============================================================================
module host_ft245_burst_read_model
  import host_ft245_pkg::*;
#(
  parameter int DATA_W          = c_default_data_w,
  parameter int FIFO_DEPTH      = 16,
  parameter int LEN_W           = c_default_len_w,
  parameter int RXF_GAP_CLKS    = 4,
  parameter int RD_TIMEOUT_CLKS = 1024
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  output logic                          HOST_FT245_RXF_N,
  input  logic                          HOST_FT245_RD_N,
  output logic [DATA_W-1:0]             HOST_FT245_READ_BYTE,
  input  logic [DATA_W-1:0]             TRANSMIT_BYTE,
  input  logic                          TRANSMIT_VALID,
  output logic                          TRANSMIT_READY,
  input  logic                          START_READ_CYCLE,
  input  logic [LEN_W-1:0]              BURST_LEN,
  output logic                          READ_CYCLE_RDY,
  output logic                          READ_CYCLE_COMPLETE,
  output logic [LEN_W-1:0]              BYTES_READ,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          PROTOCOL_ERR
);

  // The ASSERT_RXF_N cycle is the last cycle of the inactive gap, so the gap
  // state itself lasts one cycle less (never below one cycle).
  localparam logic [31:0] c_gap_last = (RXF_GAP_CLKS > 2) ? 32'(RXF_GAP_CLKS - 2) : 32'd0;

  state_t              r_state;
  logic                r_start;
  logic                r_rd_low;
  logic                r_rxf_n;
  logic [DATA_W-1:0]   r_read_byte;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_bytes_read;
  logic [31:0]         r_gap_cnt;

  logic [DATA_W-1:0]   w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_len_hit;
  logic [LEN_W-1:0]    w_bytes_inc;

  assign w_pop       = (r_state == ST_WAIT_RD_HIGH) && !r_rd_low;
  assign w_len_hit   = (r_len != '0) && (r_bytes_read == r_len);
  assign w_bytes_inc = (r_bytes_read == '1) ? r_bytes_read : r_bytes_read + 1'b1;

  host_ft245_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (TRANSMIT_VALID),
    .push_data (TRANSMIT_BYTE),
    .pop       (w_pop),
    .head_data (w_head),
    .level     (FIFO_LEVEL),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign TRANSMIT_READY       = ~w_full;
  assign HOST_FT245_RXF_N     = r_rxf_n;
  assign HOST_FT245_READ_BYTE = r_read_byte;
  assign BYTES_READ           = r_bytes_read;
  assign READ_CYCLE_RDY       = (r_state == ST_WAIT_RD_LOW);
  assign READ_CYCLE_COMPLETE  = (r_state == ST_READ_COMPLETE);

  // Register the start request and the DUT read strobe before the FSM uses them
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_start  <= 1'b0;
      r_rd_low <= 1'b0;
    end else begin
      r_start  <= START_READ_CYCLE;
      r_rd_low <= ~HOST_FT245_RD_N;
    end
  end

`ifdef FT245_PROTOCOL_CHECK_EN
  logic [31:0] r_to_cnt;
  logic        r_err;
  assign PROTOCOL_ERR = r_err;
`else
  assign PROTOCOL_ERR = 1'b0;
`endif

  // Burst sequencer: byte presentation, handshake tracking, gap timing
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_rxf_n      <= 1'b1;
      r_read_byte  <= '0;
      r_len        <= '0;
      r_bytes_read <= '0;
      r_gap_cnt    <= '0;
`ifdef FT245_PROTOCOL_CHECK_EN
      r_to_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_start) begin
            r_len        <= BURST_LEN;
            r_bytes_read <= '0;
            r_state      <= w_empty ? ST_READ_COMPLETE : ST_ASSERT_RXF_N;
          end
        end
        ST_ASSERT_RXF_N: begin
          r_read_byte <= w_head;
          r_rxf_n     <= 1'b0;
          r_state     <= ST_WAIT_RD_LOW;
`ifdef FT245_PROTOCOL_CHECK_EN
          r_to_cnt    <= '0;
`endif
        end
        ST_WAIT_RD_LOW: begin
`ifdef FT245_PROTOCOL_CHECK_EN
          if (r_rd_low) begin
            r_state <= ST_WAIT_RD_HIGH;
          end else if (r_to_cnt >= 32'(RD_TIMEOUT_CLKS)) begin
            r_err   <= 1'b1;
            r_rxf_n <= 1'b1;
            r_state <= ST_READ_COMPLETE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`else
          if (r_rd_low) begin
            r_state <= ST_WAIT_RD_HIGH;
          end
`endif
        end
        ST_WAIT_RD_HIGH: begin
          if (!r_rd_low) begin
            r_rxf_n      <= 1'b1;
            r_bytes_read <= w_bytes_inc;
            r_gap_cnt    <= '0;
            r_state      <= ST_RXF_GAP;
          end
        end
        ST_RXF_GAP: begin
          if (r_gap_cnt == c_gap_last) begin
            r_state <= (w_len_hit || w_empty) ? ST_READ_COMPLETE : ST_ASSERT_RXF_N;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        ST_READ_COMPLETE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_rxf_n <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
`ifdef FT245_PROTOCOL_CHECK_EN
      // A read strobe while no byte is offered is a DUT protocol violation
      if (r_rd_low && r_rxf_n) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

endmodule : host_ft245_burst_read_model
`default_nettype wire

// File: tb/tb_host_ft245_burst_read_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_ft245_burst_read_model
// Purpose  : Self-checking bench for the FT245 host burst read model. Bytes
//            pushed into the model are also pushed to a scoreboard queue and
//            popped when the emulated DUT read engine strobes RD_N.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_ft245_burst_read_model;

  localparam int DATA_W          = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int LEN_W           = 8;
  localparam int RXF_GAP_CLKS    = 4;
  localparam int RD_TIMEOUT_CLKS = 1024;

  logic              CLK;
  logic              RST_N;
  logic              HOST_FT245_RXF_N;
  logic              HOST_FT245_RD_N;
  logic [DATA_W-1:0] HOST_FT245_READ_BYTE;
  logic [DATA_W-1:0] TRANSMIT_BYTE;
  logic              TRANSMIT_VALID;
  logic              TRANSMIT_READY;
  logic              START_READ_CYCLE;
  logic [LEN_W-1:0]  BURST_LEN;
  logic              READ_CYCLE_RDY;
  logic              READ_CYCLE_COMPLETE;
  logic [LEN_W-1:0]  BYTES_READ;
  logic [4:0]        FIFO_LEVEL;
  logic              PROTOCOL_ERR;

  host_ft245_burst_read_model #(
    .DATA_W          (DATA_W),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .LEN_W           (LEN_W),
    .RXF_GAP_CLKS    (RXF_GAP_CLKS),
    .RD_TIMEOUT_CLKS (RD_TIMEOUT_CLKS)
  ) dut (
    .CLK                  (CLK),
    .RST_N                (RST_N),
    .HOST_FT245_RXF_N     (HOST_FT245_RXF_N),
    .HOST_FT245_RD_N      (HOST_FT245_RD_N),
    .HOST_FT245_READ_BYTE (HOST_FT245_READ_BYTE),
    .TRANSMIT_BYTE        (TRANSMIT_BYTE),
    .TRANSMIT_VALID       (TRANSMIT_VALID),
    .TRANSMIT_READY       (TRANSMIT_READY),
    .START_READ_CYCLE     (START_READ_CYCLE),
    .BURST_LEN            (BURST_LEN),
    .READ_CYCLE_RDY       (READ_CYCLE_RDY),
    .READ_CYCLE_COMPLETE  (READ_CYCLE_COMPLETE),
    .BYTES_READ           (BYTES_READ),
    .FIFO_LEVEL           (FIFO_LEVEL),
    .PROTOCOL_ERR         (PROTOCOL_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] sb[$];
  int model_level = 0;
  int n_vec  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    sb.delete();
    model_level = 0;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    n_vec++;
    if (TRANSMIT_READY !== (model_level < FIFO_DEPTH)) begin
      n_fail++;
      $display("FAIL push_ready: got %b expected %b", TRANSMIT_READY, (model_level < FIFO_DEPTH));
    end
    TRANSMIT_BYTE  = b;
    TRANSMIT_VALID = 1'b1;
    tick();
    TRANSMIT_VALID = 1'b0;
    if (model_level < FIFO_DEPTH) begin
      sb.push_back(b);
      model_level++;
    end
    n_vec++;
    if (FIFO_LEVEL !== 5'(model_level)) begin
      n_fail++;
      $display("FAIL push_level: got %0d expected %0d", FIFO_LEVEL, model_level);
    end
  endtask

  // Starts a burst on a non-empty queue and plays the DUT read engine
  task automatic run_burst(input int len, input int exp_n, input bit inject, input logic [7:0] inj_byte);
    int   nbytes;
    int   budget;
    int   gap;
    bit   done;
    bit   got_complete;
    logic [7:0] exp_b;
    nbytes = 0; budget = 0; done = 0; got_complete = 0;
    BURST_LEN        = LEN_W'(len);
    START_READ_CYCLE = 1'b1;
    tick();
    START_READ_CYCLE = 1'b0;
    tick();
    n_vec++;
    if (HOST_FT245_RXF_N !== 1'b1 || READ_CYCLE_COMPLETE !== 1'b0) begin
      n_fail++;
      $display("FAIL start_lat_k1: rxf_n %b complete %b expected 1 0", HOST_FT245_RXF_N, READ_CYCLE_COMPLETE);
    end
    tick();
    n_vec++;
    if (HOST_FT245_RXF_N !== 1'b0) begin
      n_fail++;
      $display("FAIL start_lat_k2: rxf_n %b expected 0", HOST_FT245_RXF_N);
    end
    while (!done) begin
      if (READ_CYCLE_COMPLETE === 1'b1) begin
        done = 1; got_complete = 1;
      end else if (READ_CYCLE_RDY === 1'b1) begin
        if (sb.size() == 0) begin
          exp_b = 8'h00;
          n_vec++; n_fail++;
          $display("FAIL extra_byte: got %h expected no byte", HOST_FT245_READ_BYTE);
        end else begin
          exp_b = sb.pop_front();
          n_vec++;
          if (HOST_FT245_READ_BYTE !== exp_b || HOST_FT245_RXF_N !== 1'b0) begin
            n_fail++;
            $display("FAIL read_byte: got %h rxf_n %b expected %h rxf_n 0", HOST_FT245_READ_BYTE, HOST_FT245_RXF_N, exp_b);
          end
        end
        HOST_FT245_RD_N = 1'b0;
        tick();
        tick();
        HOST_FT245_RD_N = 1'b1;
        tick();
        if (inject && nbytes == 0) begin
          TRANSMIT_BYTE  = inj_byte;
          TRANSMIT_VALID = 1'b1;
        end
        tick();
        model_level--;
        if (inject && nbytes == 0) begin
          TRANSMIT_VALID = 1'b0;
          sb.push_back(inj_byte);
          model_level++;
          n_vec++;
          if (FIFO_LEVEL !== 5'(model_level)) begin
            n_fail++;
            $display("FAIL push_pop_level: got %0d expected %0d", FIFO_LEVEL, model_level);
          end
        end
        nbytes++;
        n_vec++;
        if (HOST_FT245_RXF_N !== 1'b1) begin
          n_fail++;
          $display("FAIL rxf_release: got %b expected 1", HOST_FT245_RXF_N);
        end
        gap = 1;
        for (int i = 0; i < 64; i++) begin
          tick();
          if (READ_CYCLE_COMPLETE === 1'b1) begin
            done = 1; got_complete = 1;
            break;
          end
          if (HOST_FT245_RXF_N === 1'b0) begin
            n_vec++;
            if (gap != RXF_GAP_CLKS) begin
              n_fail++;
              $display("FAIL rxf_gap: got %0d clks expected %0d", gap, RXF_GAP_CLKS);
            end
            break;
          end
          gap++;
        end
      end else begin
        tick();
        budget++;
        if (budget > 200) done = 1;
      end
    end
    n_vec++;
    if (!got_complete) begin
      n_fail++;
      $display("FAIL burst_timeout: got no complete expected complete within budget");
    end
    n_vec++;
    if (BYTES_READ !== LEN_W'(exp_n) || nbytes != exp_n) begin
      n_fail++;
      $display("FAIL bytes_read: got %0d (seen %0d) expected %0d", BYTES_READ, nbytes, exp_n);
    end
    tick();
    n_vec++;
    if (READ_CYCLE_COMPLETE !== 1'b0 || HOST_FT245_RXF_N !== 1'b1) begin
      n_fail++;
      $display("FAIL complete_pulse: complete %b rxf_n %b expected 0 1", READ_CYCLE_COMPLETE, HOST_FT245_RXF_N);
    end
    n_vec++;
    if (FIFO_LEVEL !== 5'(model_level)) begin
      n_fail++;
      $display("FAIL post_level: got %0d expected %0d", FIFO_LEVEL, model_level);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (HOST_FT245_RXF_N !== 1'b1 || HOST_FT245_READ_BYTE !== 8'h00 || TRANSMIT_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_a: rxf_n %b byte %h ready %b expected 1 00 1", HOST_FT245_RXF_N, HOST_FT245_READ_BYTE, TRANSMIT_READY);
    end
    n_vec++;
    if (READ_CYCLE_RDY !== 1'b0 || READ_CYCLE_COMPLETE !== 1'b0 || BYTES_READ !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_b: rdy %b complete %b bytes %0d expected 0 0 0", READ_CYCLE_RDY, READ_CYCLE_COMPLETE, BYTES_READ);
    end
    n_vec++;
    if (FIFO_LEVEL !== 5'd0 || PROTOCOL_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_c: level %0d err %b expected 0 0", FIFO_LEVEL, PROTOCOL_ERR);
    end
  endtask

  task automatic test_basic();
    push_byte(8'hA5);
    push_byte(8'h5A);
    run_burst(2, 2, 1'b0, 8'h00);
  endtask

  task automatic test_empty();
    BURST_LEN        = 8'd3;
    START_READ_CYCLE = 1'b1;
    tick();
    START_READ_CYCLE = 1'b0;
    n_vec++;
    if (READ_CYCLE_COMPLETE !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_k0: complete %b expected 0", READ_CYCLE_COMPLETE);
    end
    tick();
    n_vec++;
    if (READ_CYCLE_COMPLETE !== 1'b1 || HOST_FT245_RXF_N !== 1'b1 || BYTES_READ !== 8'd0) begin
      n_fail++;
      $display("FAIL empty_k1: complete %b rxf_n %b bytes %0d expected 1 1 0", READ_CYCLE_COMPLETE, HOST_FT245_RXF_N, BYTES_READ);
    end
    tick();
    n_vec++;
    if (READ_CYCLE_COMPLETE !== 1'b0 || HOST_FT245_RXF_N !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_k2: complete %b rxf_n %b expected 0 1", READ_CYCLE_COMPLETE, HOST_FT245_RXF_N);
    end
  endtask

  task automatic test_full_drain();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) push_byte(8'((i * 37) + 11));
    n_vec++;
    if (TRANSMIT_READY !== 1'b0 || FIFO_LEVEL !== 5'd16) begin
      n_fail++;
      $display("FAIL full: ready %b level %0d expected 0 16", TRANSMIT_READY, FIFO_LEVEL);
    end
    run_burst(0, FIFO_DEPTH, 1'b0, 8'h00);
  endtask

  task automatic test_short_queue();
    push_byte(8'h01);
    push_byte(8'h80);
    push_byte(8'hFF);
    run_burst(5, 3, 1'b0, 8'h00);
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h40 + i));
    run_burst(1, 1, 1'b1, 8'hC3);
    run_burst(0, 8, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_burst();
    int budget;
    bit seen_complete;
    push_byte(8'h3C);
    push_byte(8'hC3);
    BURST_LEN        = 8'd2;
    START_READ_CYCLE = 1'b1;
    tick();
    START_READ_CYCLE = 1'b0;
    budget = 0;
    while (READ_CYCLE_RDY !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    n_vec++;
    if (READ_CYCLE_RDY !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rdy: rdy %b expected 1", READ_CYCLE_RDY);
    end
    HOST_FT245_RD_N = 1'b0;
    tick();
    tick();
    n_vec++;
    if (HOST_FT245_RXF_N !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rxf_low: rxf_n %b expected 0", HOST_FT245_RXF_N);
    end
    #2;
    RST_N = 1'b0;
    #1;
    n_vec++;
    if (HOST_FT245_RXF_N !== 1'b1 || FIFO_LEVEL !== 5'd0 || READ_CYCLE_COMPLETE !== 1'b0 || BYTES_READ !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: rxf_n %b level %0d complete %b bytes %0d expected 1 0 0 0",
               HOST_FT245_RXF_N, FIFO_LEVEL, READ_CYCLE_COMPLETE, BYTES_READ);
    end
    HOST_FT245_RD_N = 1'b1;
    sb.delete();
    model_level = 0;
    seen_complete = 0;
    repeat (3) begin
      tick();
      if (READ_CYCLE_COMPLETE === 1'b1) seen_complete = 1;
    end
    RST_N = 1'b1;
    repeat (4) begin
      tick();
      if (READ_CYCLE_COMPLETE === 1'b1) seen_complete = 1;
    end
    n_vec++;
    if (seen_complete) begin
      n_fail++;
      $display("FAIL mid_no_complete: got complete pulse expected none");
    end
    test_basic();
  endtask

  task automatic test_protocol();
`ifdef FT245_PROTOCOL_CHECK_EN
    int budget;
    push_byte(8'h77);
    BURST_LEN        = 8'd1;
    START_READ_CYCLE = 1'b1;
    tick();
    START_READ_CYCLE = 1'b0;
    budget = 0;
    while (READ_CYCLE_COMPLETE !== 1'b1 && budget < RD_TIMEOUT_CLKS + 50) begin
      tick();
      budget++;
    end
    n_vec++;
    if (READ_CYCLE_COMPLETE !== 1'b1 || PROTOCOL_ERR !== 1'b1 || HOST_FT245_RXF_N !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: complete %b err %b rxf_n %b expected 1 1 1", READ_CYCLE_COMPLETE, PROTOCOL_ERR, HOST_FT245_RXF_N);
    end
    n_vec++;
    if (budget < RD_TIMEOUT_CLKS) begin
      n_fail++;
      $display("FAIL timeout_early: got %0d clks expected at least %0d", budget, RD_TIMEOUT_CLKS);
    end
    apply_reset();
`else
    n_vec++;
    if (PROTOCOL_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL err_tied: got %b expected 0", PROTOCOL_ERR);
    end
`endif
  endtask

  initial begin
    RST_N            = 1'b0;
    HOST_FT245_RD_N  = 1'b1;
    TRANSMIT_BYTE    = '0;
    TRANSMIT_VALID   = 1'b0;
    START_READ_CYCLE = 1'b0;
    BURST_LEN        = '0;
    test_reset();
    test_basic();
    test_empty();
    test_full_drain();
    test_short_queue();
    test_push_pop();
    test_reset_mid_burst();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_host_ft245_burst_read_model
`default_nettype wire
